fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin, packet-locked write arbiter sharing one synchronous FIFO between NREQ producers.
//  - Each producer offers beats via valid/ready with a last marker.
//  - The arbiter grants one producer at a time and holds the grant until that producer's last beat is written.
//  - Drives the FIFO write side (wr_en/data_in) and obeys its full flag; the read side is untouched.
// PARAMETERS
//  NREQ      4   number of requesters (>=2)
//  DWIDTH    8   beat data width; matches FIFO DWIDTH
//  IDW       2   grant index width, = clog2(NREQ)
//  MAX_BEATS 16  max beats per packet before forced release (>=1)
//  CW        5   beat counter width, = clog2(MAX_BEATS+1)
// PORTS
//  clk         in   1            system clock, all logic on rising edge
//  rst         in   1            synchronous, active-high reset
//  req_valid   in   NREQ         per-requester beat valid
//  req_last    in   NREQ         per-requester last-beat-of-packet marker
//  req_data    in   NREQ*DWIDTH  per-requester data; requester i at [i*DWIDTH +: DWIDTH]
//  req_ready   out  NREQ         per-requester accept; beat transfers when valid&ready
//  fifo_full   in   1            FIFO full flag
//  fifo_wr_en  out  1            FIFO write enable
//  fifo_data   out  DWIDTH       FIFO write data
//  busy        out  1            a packet grant is held
//  grant_id    out  IDW          index of current/most recent owner
//  overlen     out  1            one-cycle pulse on forced release at MAX_BEATS
// BEHAVIOUR
//  Reset (sync, rst=1 at posedge):
//  - state=IDLE, owner=0, last_grant=NREQ-1 (requester 0 wins first), beat_cnt=0.
//  - Outputs: busy=0, grant_id=0, overlen=0, req_ready=0, fifo_wr_en=0, fifo_data=0.
//  FSM IDLE -> ARB:
//  - When any req_valid=1, pick the first set bit scanning from last_grant+1 upward, wrapping modulo NREQ.
//  - Register owner=pick and grant_id=pick; set busy=1; go to BURST.
//  - Arbitration costs exactly 1 cycle; no beat is accepted in IDLE.
//  - With no requester valid, stay in IDLE.
//  FSM BURST:
//  - req_ready[owner] = !fifo_full; all other req_ready bits = 0.
//  - fifo_wr_en = req_valid[owner] & !fifo_full (combinational, same cycle).
//  - fifo_data = req_data[owner] muxed combinationally; 0 when not writing.
//  - On an accepted beat: beat_cnt++.
//  - If req_last[owner]=1, or beat_cnt+1==MAX_BEATS: last_grant<=owner, beat_cnt<=0, busy<=0, go to IDLE.
//  - Forced release (MAX_BEATS reached without req_last): overlen=1 for exactly that one cycle.
//  - Owner deasserting valid mid-packet: grant is held and the arbiter waits; no timeout.
//  Boundaries:
//  - fifo_full=1: no write, no ready, state and count hold. Writes never occur while full.
//  - Simultaneous requests: round-robin only; a releasing owner is lowest priority next round.
//  - Single-beat packet (valid&last first cycle): 1 write, then IDLE; 2 cycles per packet minimum.
//  - req_valid/last of non-owners ignored in BURST; their beats must be held, not dropped.
//  - rst mid-packet: grant dropped immediately next cycle; the FIFO is reset by the same rst at system level.
//  - grant_id holds the last owner in IDLE (for debug/tagging).
// STRUCTURE
//  Shared package/header: IDLE/BURST state encoding localparams, clog2 helper for IDW/CW.
//  Sub-module rr_pick (NREQ): combinational round-robin picker.
//  - Inputs: req vector, last_grant. Outputs: pick index, any.
//  - Reused by future read-side schedulers.
//  Top holds the FSM, beat counter and data mux; the FIFO is instantiated by the parent, not here.
// TESTING
//  1. Only req0 sends a 3-beat packet A1,A2,A3(last) -> FIFO gets A1..A3 on 3 consecutive cycles after 1 arb cycle; busy drops after A3.
//  2. All 4 valid with 1-beat packets, repeated -> grant order 0,1,2,3,0; each grant_id matches its written data tag.
//  3. req1 mid-packet, fifo_full=1 for 5 cycles -> no wr_en, req_ready=0; resume writes remaining beats; no loss or duplication.
//  4. req2 sends 20 beats, no last, MAX_BEATS=16 -> 16 writes, overlen pulses once, next grant goes to the other valid requester.
//  5. rst asserted after beat 2 of a 4-beat packet -> next cycle busy=0, wr_en=0, grant_id=0; req0 wins first after rst.
//  6. req3 packet with valid gaps (valid low 2 cycles) while req0 valid -> grant stays on 3 until its last; req0 is served next.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write arbiter.
//   state_t : FSM encoding (IDLE arbitrates, BURST forwards beats of the owner)
//   clog2   : ceiling log2 used to size grant index and beat counter widths
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Returns ceil(log2(n)); clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Scans req starting one above last_grant, wrapping modulo NREQ, and returns
// the first set index.
//   req        : request vector
//   last_grant : index granted most recently (lowest priority this round)
//   pick       : chosen index (0 when nothing requests)
//   any        : at least one request bit set
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
  output logic [IDW-1:0]  pick,
  output logic            any
);

  logic [NREQ-1:0] shifted;

  always_comb begin
    pick    = '0;
    any     = 1'b0;
    shifted = '0;
    for (int i = 1; i <= NREQ; i++) begin
      // Shift instead of a variable bit-select so the index width never
      // has to match the vector width.
      shifted = req >> ((int'(last_grant) + i) % NREQ);
      if (!any && shifted[0]) begin
        any  = 1'b1;
        pick = IDW'((int'(last_grant) + i) % NREQ);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locked write arbiter in front of one synchronous FIFO.
// A requester is granted after one arbitration cycle and keeps the grant until
// its last beat (or MAX_BEATS beats) has been written into the FIFO.
//
// Handshake: a beat moves from requester i when req_valid[i] & req_ready[i]
// at a rising edge; req_ready never depends on req_valid of the same requester,
// and the FIFO write fires in the same cycle as the accepted beat.
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   req_valid   : per-requester beat valid
//   req_last    : per-requester last-beat marker
//   req_data    : packed per-requester data, requester i at [i*DWIDTH +: DWIDTH]
//   req_ready   : per-requester accept
//   fifo_full   : FIFO full flag
//   fifo_wr_en  : FIFO write enable
//   fifo_data   : FIFO write data (0 when not writing)
//   busy        : a packet grant is held
//   grant_id    : current or most recent owner
//   overlen     : pulse on the beat that forces release at MAX_BEATS
//   state       : FSM state for observation
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DWIDTH    = 8,
  parameter int IDW       = clog2(NREQ),
  parameter int MAX_BEATS = 16,
  parameter int CW        = clog2(MAX_BEATS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_last,
  input  logic [NREQ*DWIDTH-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   fifo_full,
  output logic                   fifo_wr_en,
  output logic [DWIDTH-1:0]      fifo_data,
  output logic                   busy,
  output logic [IDW-1:0]         grant_id,
  output logic                   overlen,
  output state_t                 state
);

  state_t            state_q, state_d;
  logic [IDW-1:0]    owner_q, owner_d;
  logic [IDW-1:0]    last_grant_q, last_grant_d;
  logic [CW-1:0]     beat_cnt_q, beat_cnt_d;

  logic [DWIDTH-1:0] data_arr [NREQ];
  logic [IDW-1:0]    pick;
  logic              any;

  logic              own_valid;
  logic              own_last;
  logic [DWIDTH-1:0] own_data;
  logic              accept;
  logic              at_cap;
  logic              done;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign data_arr[i] = req_data[i*DWIDTH +: DWIDTH];
  end

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .pick       (pick),
    .any        (any)
  );

  always_comb begin
    own_valid = req_valid[owner_q];
    own_last  = req_last[owner_q];
    own_data  = data_arr[owner_q];
    accept    = (state_q == BURST) && own_valid && !fifo_full;
    at_cap    = (beat_cnt_q + CW'(1)) == CW'(MAX_BEATS);
    done      = accept && (own_last || at_cap);
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_data    = '0;
    overlen      = 1'b0;

    case (state_q)
      IDLE: begin
        if (any) begin
          owner_d = pick;
          state_d = BURST;
        end
      end
      BURST: begin
        if (!fifo_full) req_ready[owner_q] = 1'b1;
        fifo_wr_en = accept;
        if (accept) begin
          fifo_data  = own_data;
          beat_cnt_d = beat_cnt_q + CW'(1);
        end
        if (done) begin
          // Releasing owner becomes lowest priority for the next round.
          last_grant_d = owner_q;
          beat_cnt_d   = '0;
          state_d      = IDLE;
          overlen      = !own_last;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_grant_q <= IDW'(NREQ - 1);
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  assign busy     = (state_q == BURST);
  assign grant_id = owner_q;
  assign state    = state_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NREQ=4, DWIDTH=8, MAX_BEATS=16).
// Beat data carries the requester index in its upper nibble, so every FIFO
// write is also checked against grant_id.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;
  import fifo_wr_arbiter_pkg::*;

  localparam int NREQ = 4;
  localparam int DW   = 8;

  logic            clk;
  logic            rst;
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_last;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0] req_ready;
  logic            fifo_full;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_data;
  logic            busy;
  logic [1:0]      grant_id;
  logic            overlen;
  state_t          dbg_state;

  logic [DW-1:0]   exp_q[$];
  int              n_vec;
  int              n_miss;
  int              n_ovl;

  fifo_wr_arbiter #(
    .NREQ(NREQ), .DWIDTH(DW), .IDW(2), .MAX_BEATS(16), .CW(5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_data  (fifo_data),
    .busy       (busy),
    .grant_id   (grant_id),
    .overlen    (overlen),
    .state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every FIFO write must be the next expected beat, tagged with
  // the current grant. Writes during reset are ignored (the FIFO is reset too).
  always @(negedge clk) begin
    if (!rst) begin
      if (fifo_wr_en) begin
        check("wr_gid", grant_id, fifo_data[7:4]);
        check("wr_full", fifo_full, 0);
        if (exp_q.size() == 0) check("wr_unexpected", fifo_data, 0);
        else check("wr_data", fifo_data, exp_q.pop_front());
      end
      if (overlen) begin
        n_ovl++;
        check("ovl_with_wr", fifo_wr_en, 1);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Send n beats from requester id; data = {id, base+b}. Optional valid gap of
  // gap_len cycles before beat gap_at.
  task automatic pkt(input int id, input int n, input bit last_flag,
                     input int gap_at, input int gap_len, input int base);
    for (int b = 0; b < n; b++) begin
      bit acc;
      int waited;
      if (b == gap_at) begin
        req_valid[id] = 1'b0;
        req_last[id]  = 1'b0;
        repeat (gap_len) tick();
      end
      req_valid[id] = 1'b1;
      req_last[id]  = last_flag && (b == n - 1);
      req_data[id*DW +: DW] = {id[3:0], 4'(base + b)};
      acc    = 1'b0;
      waited = 0;
      while (!acc && waited < 200) begin
        @(negedge clk);
        acc = req_ready[id];
        tick();
        waited++;
      end
      check("pkt_accept", acc, 1);
    end
    req_valid[id] = 1'b0;
    req_last[id]  = 1'b0;
  endtask

  // ---------------- tests ----------------
  initial begin
    n_vec = 0; n_miss = 0; n_ovl = 0;
    rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;

    // Reset state
    tick();
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_gid", grant_id, 0);
    check("rst_ovl", overlen, 0);
    check("rst_ready", req_ready, 0);
    check("rst_wr", fifo_wr_en, 0);
    check("rst_data", fifo_data, 0);
    tick();
    rst = 1'b0;

    // 1: req0 3-beat packet, one arbitration cycle then 3 back-to-back writes
    exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03);
    req_valid[0] = 1'b1; req_data[7:0] = 8'h01;
    @(negedge clk);
    check("t1_arb_wr", fifo_wr_en, 0);
    check("t1_arb_busy", busy, 0);
    tick();
    @(negedge clk);
    check("t1_b1_wr", fifo_wr_en, 1);
    check("t1_ready", req_ready, 4'b0001);
    check("t1_busy", busy, 1);
    tick();
    req_data[7:0] = 8'h02;
    @(negedge clk);
    check("t1_b2_wr", fifo_wr_en, 1);
    tick();
    req_data[7:0] = 8'h03; req_last[0] = 1'b1;
    @(negedge clk);
    check("t1_b3_wr", fifo_wr_en, 1);
    tick();
    req_valid[0] = 1'b0; req_last[0] = 1'b0;
    @(negedge clk);
    check("t1_end_busy", busy, 0);
    check("t1_end_wr", fifo_wr_en, 0);
    check("t1_end_gid", grant_id, 0);
    check("t1_drain", exp_q.size(), 0);
    tick();

    // 2: all four valid with single-beat packets -> 0,1,2,3,0,1,2,3
    do_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 4; i++) exp_q.push_back(8'((i << 4) | k));
    fork
      begin pkt(0, 1, 1, -1, 0, 0); pkt(0, 1, 1, -1, 0, 1); end
      begin pkt(1, 1, 1, -1, 0, 0); pkt(1, 1, 1, -1, 0, 1); end
      begin pkt(2, 1, 1, -1, 0, 0); pkt(2, 1, 1, -1, 0, 1); end
      begin pkt(3, 1, 1, -1, 0, 0); pkt(3, 1, 1, -1, 0, 1); end
    join
    check("t2_drain", exp_q.size(), 0);

    // 3: req1 stalled by fifo_full for 5 cycles mid-packet
    do_reset();
    for (int b = 0; b < 4; b++) exp_q.push_back(8'(8'h10 + b));
    fork
      pkt(1, 4, 1, -1, 0, 0);
      begin
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          if (fifo_wr_en) break;
        end
        check("t3_first_wr", fifo_wr_en, 1);
        tick();
        fifo_full = 1'b1;
        repeat (5) begin
          @(negedge clk);
          check("t3_full_wr", fifo_wr_en, 0);
          check("t3_full_ready", req_ready, 0);
          check("t3_full_busy", busy, 1);
          tick();
        end
        fifo_full = 1'b0;
      end
    join
    check("t3_drain", exp_q.size(), 0);

    // 4: req2 sends 20 beats without last -> forced release after 16, req0 next
    do_reset();
    for (int b = 0; b < 16; b++) exp_q.push_back(8'(8'h20 + b));
    exp_q.push_back(8'h00);
    for (int b = 0; b < 4; b++) exp_q.push_back(8'(8'h20 + b));
    fork
      pkt(2, 20, 0, -1, 0, 0);
      begin tick(); tick(); pkt(0, 1, 1, -1, 0, 0); end
    join
    check("t4_drain", exp_q.size(), 0);
    check("t4_ovl_count", n_ovl, 1);

    // 5: reset after beat 2 of a req1 packet; req0 wins first afterwards
    do_reset();
    exp_q.push_back(8'h10); exp_q.push_back(8'h11); exp_q.push_back(8'h00);
    req_valid[1] = 1'b1; req_data[15:8] = 8'h10;
    tick();
    tick();
    req_data[15:8] = 8'h11;
    tick();
    rst = 1'b1;
    req_data[15:8] = 8'h12;
    req_valid[0] = 1'b1; req_last[0] = 1'b1; req_data[7:0] = 8'h00;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_wr", fifo_wr_en, 0);
    check("t5_rst_gid", grant_id, 0);
    check("t5_rst_ready", req_ready, 0);
    tick();
    @(negedge clk);
    check("t5_arb_gid", grant_id, 0);
    check("t5_arb_busy", busy, 1);
    tick();
    req_valid = '0; req_last = '0;
    @(negedge clk);
    check("t5_end_busy", busy, 0);
    check("t5_drain", exp_q.size(), 0);
    tick();

    // 6: req3 packet with a 2-cycle valid gap while req0 waits
    do_reset();
    for (int b = 0; b < 4; b++) exp_q.push_back(8'(8'h30 + b));
    exp_q.push_back(8'h00);
    fork
      pkt(3, 4, 1, 2, 2, 0);
      begin tick(); tick(); tick(); pkt(0, 1, 1, -1, 0, 0); end
    join
    tick();
    @(negedge clk);
    check("t6_drain", exp_q.size(), 0);
    check("t6_end_gid", grant_id, 0);
    check("ovl_total", n_ovl, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
